mips_alu_md: RTL

Parametrised successor to the single-cycle datapath ALU. It keeps the combinational ALU path with a 4-bit control that is a superset of the 3-bit AND/OR/ADD/SUB/SLT encoding. It adds XOR, NOR and SLTU, plus an iterative multiply/divide unit with architectural HI/LO registers. It sits in the execute stage; the controller stalls on `md_busy` for MULT/DIV sequences and reads HI/LO for MFHI/MFLO.

---
 rtl/mips_alu_pkg.sv | 28 ++
 rtl/mips_alu_md_if.sv | 26 ++
 rtl/mips_muldiv.sv | 136 +++++++++++++
 rtl/mips_alu_md.sv | 54 +++++
 4 files changed

// File: rtl/mips_alu_pkg.sv
// Shared constants and types for the execute-stage ALU and multiply/divide unit.
package mips_alu_pkg;

  // Combinational ALU operation codes.
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  // Multiply/divide unit operation codes; 7 is reserved and behaves as NONE.
  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic {
    IDLE,
    RUN
  } md_state_e;

endpackage

// File: rtl/mips_alu_md_if.sv
// Execute-stage bus between the controller/datapath and the ALU + mul/div unit.
interface mips_alu_md_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [3:0]       alucontrol;
  logic [WIDTH-1:0] aluout;
  logic             zero;
  logic [2:0]       md_op;
  logic             md_start;
  logic             md_busy;
  logic             md_done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output srca, srcb, alucontrol, md_op, md_start,
    input  aluout, zero, md_busy, md_done, hi, lo
  );

  modport slave (
    input  srca, srcb, alucontrol, md_op, md_start,
    output aluout, zero, md_busy, md_done, hi, lo
  );
endinterface

// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit: one bit per cycle on operand magnitudes, signs fixed at the end.
module mips_muldiv
  import mips_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_srca,
  input  logic [WIDTH-1:0] i_srcb,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned    CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  md_state_e        r_state, w_state_next;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_wh, r_wl;      // working pair: product or remainder/quotient
  logic [WIDTH-1:0] r_b;             // multiplicand or divisor magnitude
  logic [WIDTH-1:0] r_dividend;      // original signed dividend, for divide-by-zero
  logic             r_is_div, r_neg_q, r_neg_r;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_done;

  logic             w_accept, w_is_md, w_signed, w_last;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [WIDTH:0]   w_msum, w_trial, w_diff;
  logic [WIDTH-1:0] w_step_hi, w_step_lo, w_res_hi, w_res_lo;
  logic [2*WIDTH-1:0] w_prod;

  assign w_accept = i_start && (r_state == IDLE);
  assign w_is_md  = (i_op == MD_MULT) || (i_op == MD_MULTU) ||
                    (i_op == MD_DIV)  || (i_op == MD_DIVU);
  assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
  assign w_mag_a  = (w_signed && i_srca[WIDTH-1]) ? -i_srca : i_srca;
  assign w_mag_b  = (w_signed && i_srcb[WIDTH-1]) ? -i_srcb : i_srcb;
  assign w_last   = (r_state == RUN) && (r_cnt == LastCnt);

  // One iteration step plus final sign/divide-by-zero correction.
  always_comb begin
    w_msum  = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_b} : '0);
    w_trial = {r_wh, r_wl[WIDTH-1]};
    w_diff  = w_trial - {1'b0, r_b};
    if (r_is_div) begin
      // Restoring step: keep the subtraction only if it did not go negative.
      w_step_hi = w_diff[WIDTH] ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
      w_step_lo = {r_wl[WIDTH-2:0], ~w_diff[WIDTH]};
    end else begin
      {w_step_hi, w_step_lo} = {w_msum, r_wl[WIDTH-1:1]};
    end
    w_prod = {w_step_hi, w_step_lo};
    if (!r_is_div) begin
      {w_res_hi, w_res_lo} = r_neg_q ? -w_prod : w_prod;
    end else if (r_b == '0) begin
      w_res_hi = r_dividend;
      w_res_lo = '1;
    end else begin
      w_res_hi = r_neg_r ? -w_step_hi : w_step_hi;
      w_res_lo = r_neg_q ? -w_step_lo : w_step_lo;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next state: run for WIDTH cycles after a multiply/divide accept.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept && w_is_md) w_state_next = RUN;
      RUN:     if (r_cnt == LastCnt)    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand latch, iteration, HI/LO writes and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_wh       <= '0;
      r_wl       <= '0;
      r_b        <= '0;
      r_dividend <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        case (i_op)
          MD_MTHI: r_hi <= i_srca;
          MD_MTLO: r_lo <= i_srca;
          MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
            r_cnt      <= '0;
            r_wh       <= '0;
            r_wl       <= w_mag_a;
            r_b        <= w_mag_b;
            r_dividend <= i_srca;
            r_is_div   <= (i_op == MD_DIV) || (i_op == MD_DIVU);
            r_neg_q    <= w_signed && (i_srca[WIDTH-1] ^ i_srcb[WIDTH-1]);
            r_neg_r    <= w_signed && i_srca[WIDTH-1];
          end
          default: ;
        endcase
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt + 1'b1;
        r_wh  <= w_step_hi;
        r_wl  <= w_step_lo;
        if (w_last) begin
          r_cnt  <= '0;
          r_hi   <= w_res_hi;
          r_lo   <= w_res_lo;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = (r_state == RUN);
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/mips_alu_md.sv
// Execute-stage ALU (combinational) with an attached iterative multiply/divide unit.
module mips_alu_md
  import mips_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  mips_alu_md_if.slave bus
);

  logic [WIDTH-1:0] w_sum, w_diff, w_aluout;
  logic             w_ovf, w_slt, w_sltu;

  // Combinational ALU; SLT uses sign xor overflow so it is correct across the wrap.
  always_comb begin
    w_sum  = bus.srca + bus.srcb;
    w_diff = bus.srca - bus.srcb;
    w_ovf  = (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]) & (w_diff[WIDTH-1] ^ bus.srca[WIDTH-1]);
    w_slt  = w_diff[WIDTH-1] ^ w_ovf;
    w_sltu = bus.srca < bus.srcb;
    w_aluout = '0;
    case (bus.alucontrol)
      ALU_AND:  w_aluout = bus.srca & bus.srcb;
      ALU_OR:   w_aluout = bus.srca | bus.srcb;
      ALU_ADD:  w_aluout = w_sum;
      ALU_SUB:  w_aluout = w_diff;
      ALU_SLT:  w_aluout = WIDTH'(w_slt);
      ALU_XOR:  w_aluout = bus.srca ^ bus.srcb;
      ALU_NOR:  w_aluout = ~(bus.srca | bus.srcb);
      ALU_SLTU: w_aluout = WIDTH'(w_sltu);
      default:  w_aluout = '0;
    endcase
  end

  assign bus.aluout = w_aluout;
  assign bus.zero   = (w_aluout == '0);

  mips_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .i_start (bus.md_start),
    .i_op    (bus.md_op),
    .i_srca  (bus.srca),
    .i_srcb  (bus.srcb),
    .o_busy  (bus.md_busy),
    .o_done  (bus.md_done),
    .o_hi    (bus.hi),
    .o_lo    (bus.lo)
  );

endmodule
